// File: rtl/fifo_wr_framer.sv
// Write-side packet framer: buffers one packet, then pushes a length-1 header
// followed by the payload into the async FIFO write port.
module fifo_wr_framer #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned LEN_ADDR = 4
) (
   input  logic             clk_w,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_last,
   input  logic             fifo_full,
   output logic             fifo_wen,
   output logic [WIDTH-1:0] fifo_wdata,
   output logic             ovf_err,
   output logic             busy
);

   localparam int unsigned MAX_LEN = 1 << LEN_ADDR;
   localparam int unsigned CW      = LEN_ADDR + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   len_q, len_d;
   logic            ovf_q, ovf_d;
   logic [WIDTH-1:0] buf_q [MAX_LEN];

   logic            accept_c;
   logic            write_c;
   logic            buf_we_c;
   logic [CW-1:0]   len_m1_c;

   assign len_m1_c   = len_q - CW'(1);
   assign s_ready    = (state_q == ST_IDLE) || (state_q == ST_DROP);
   assign accept_c   = s_valid && s_ready;
   assign write_c    = ((state_q == ST_HDR) || (state_q == ST_PAYLOAD)) && !fifo_full;
   assign fifo_wen   = write_c;
   assign busy       = (cnt_q != '0) || (state_q != ST_IDLE);
   assign ovf_err    = ovf_q;

   // Write-data mux; held stable by the registered state while fifo_full stalls
   always_comb begin
      fifo_wdata = '0;
      case (state_q)
         ST_HDR:     fifo_wdata = WIDTH'(len_m1_c);
         ST_PAYLOAD: fifo_wdata = buf_q[idx_q[LEN_ADDR-1:0]];
         default:    fifo_wdata = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      len_d    = len_q;
      ovf_d    = 1'b0;
      buf_we_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               buf_we_c = 1'b1;
               cnt_d    = cnt_q + CW'(1);
               if (s_last) begin
                  len_d   = cnt_q + CW'(1);
                  state_d = ST_HDR;
               end else if (cnt_q == CW'(MAX_LEN - 1)) begin
                  // Buffer full without a last byte: discard the rest of the packet
                  state_d = ST_DROP;
                  ovf_d   = 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         ST_HDR: begin
            if (write_c) begin
               idx_d   = '0;
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (write_c) begin
               idx_d = idx_q + CW'(1);
               if (idx_q == len_m1_c) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (accept_c && s_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   // Packet storage is intentionally not reset
   always_ff @(posedge clk_w) begin
      if (buf_we_c) buf_q[cnt_q[LEN_ADDR-1:0]] <= s_data;
   end

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed bench for fifo_wr_framer: a per-cycle vector table plus hand-written
// sequences for max-length, overflow and mid-packet reset.
module tb_fifo_wr_framer;

   logic       clk_w = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;
   logic       fifo_full;
   logic       fifo_wen;
   logic [7:0] fifo_wdata;
   logic       ovf_err;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_w = ~clk_w;

   fifo_wr_framer #(.WIDTH(8), .LEN_ADDR(4)) dut (
      .clk_w      (clk_w),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .fifo_full  (fifo_full),
      .fifo_wen   (fifo_wen),
      .fifo_wdata (fifo_wdata),
      .ovf_err    (ovf_err),
      .busy       (busy)
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic       f;
      logic       er;
      logic       ew;
      logic       cd;
      logic [7:0] ed;
      logic       eb;
      logic       eo;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, input logic [7:0] d, input logic l,
                               input logic f, input logic er, input logic ew,
                               input logic cd, input logic [7:0] ed,
                               input logic eb, input logic eo);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.f = f;
      t.er = er; t.ew = ew; t.cd = cd; t.ed = ed; t.eb = eb; t.eo = eo;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input int idx, input logic er, input logic ew,
                        input logic cd, input logic [7:0] ed, input logic eb,
                        input logic eo);
      logic ok;
      ok = (s_ready === er) && (fifo_wen === ew) && (busy === eb) && (ovf_err === eo);
      if (ew || cd) ok = ok && (fifo_wdata === ed);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s[%0d]: got rdy=%b wen=%b wd=%h busy=%b ovf=%b, want rdy=%b wen=%b wd=%h busy=%b ovf=%b",
                  name, idx, s_ready, fifo_wen, fifo_wdata, busy, ovf_err,
                  er, ew, ed, eb, eo);
      end
   endtask

   // Drive one cycle of inputs, check outputs on the falling edge, then advance
   task automatic step(input string name, input int idx, input logic v,
                       input logic [7:0] d, input logic l, input logic f,
                       input logic er, input logic ew, input logic cd,
                       input logic [7:0] ed, input logic eb, input logic eo);
      s_valid   = v;
      s_data    = d;
      s_last    = l;
      fifo_full = f;
      @(negedge clk_w);
      check(name, idx, er, ew, cd, ed, eb, eo);
      @(posedge clk_w);
      #1;
   endtask

   initial begin
      // Basic 3-byte packet, then single byte
      add(1, 8'hA1, 0, 0,  1, 0, 0, 8'h00, 0, 0);
      add(1, 8'hA2, 0, 0,  1, 0, 0, 8'h00, 1, 0);
      add(1, 8'hA3, 1, 0,  1, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'h02, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hA1, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hA2, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hA3, 1, 0);
      add(1, 8'h5A, 1, 0,  1, 0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'h5A, 1, 0);
      // 3-byte packet stalled by full for 5 cycles after the A1 write
      add(1, 8'hA1, 0, 0,  1, 0, 0, 8'h00, 0, 0);
      add(1, 8'hA2, 0, 0,  1, 0, 0, 8'h00, 1, 0);
      add(1, 8'hA3, 1, 0,  1, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'h02, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hA1, 1, 0);
      for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 1,  0, 0, 1, 8'hA2, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hA2, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hA3, 1, 0);
      // Full rising on HDR entry, then toggling every cycle
      add(1, 8'hB1, 0, 0,  1, 0, 0, 8'h00, 0, 0);
      add(1, 8'hB2, 1, 0,  1, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 1,  0, 0, 1, 8'h01, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'h01, 1, 0);
      add(0, 8'h00, 0, 1,  0, 0, 1, 8'hB1, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hB1, 1, 0);
      add(0, 8'h00, 0, 1,  0, 0, 1, 8'hB2, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hB2, 1, 0);
      // s_valid gap mid-packet: count holds
      add(1, 8'hC1, 0, 0,  1, 0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0);
      add(1, 8'hC2, 1, 0,  1, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'h01, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hC1, 1, 0);
      add(0, 8'h00, 0, 0,  0, 1, 0, 8'hC2, 1, 0);
      add(0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 0);

      rst_n     = 1'b0;
      s_valid   = 1'b0;
      s_data    = 8'h00;
      s_last    = 1'b0;
      fifo_full = 1'b0;
      repeat (2) @(posedge clk_w);
      #1;
      check("reset", 0, 1, 0, 1, 8'h00, 0, 0);
      @(negedge clk_w);
      rst_n = 1'b1;
      @(posedge clk_w);
      #1;

      for (int i = 0; i < vecs.size(); i++)
         step("table", i, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f,
              vecs[i].er, vecs[i].ew, vecs[i].cd, vecs[i].ed, vecs[i].eb, vecs[i].eo);

      // Exactly MAX_LEN bytes: legal, header 0F
      for (int i = 0; i < 16; i++)
         step("max_in", i, 1, 8'(i), (i == 15), 0, 1, 0, 0, 8'h00, (i != 0), 0);
      step("max_hdr", 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h0F, 1, 0);
      for (int i = 0; i < 16; i++)
         step("max_pay", i, 0, 8'h00, 0, 0, 0, 1, 0, 8'(i), 1, 0);

      // 17 bytes: dropped, ovf pulse once, no FIFO writes
      for (int i = 0; i < 16; i++)
         step("ovf_in", i, 1, 8'(8'h40 + i), 0, 0, 1, 0, 0, 8'h00, (i != 0), 0);
      step("ovf_pulse", 0, 1, 8'h50, 1, 0, 1, 0, 0, 8'h00, 1, 1);
      step("ovf_after", 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      step("ovf_after", 1, 1, 8'hD1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      step("ovf_next", 0, 1, 8'hD2, 1, 0, 1, 0, 0, 8'h00, 1, 0);
      step("ovf_next", 1, 0, 8'h00, 0, 0, 0, 1, 0, 8'h01, 1, 0);
      step("ovf_next", 2, 0, 8'h00, 0, 0, 0, 1, 0, 8'hD1, 1, 0);
      step("ovf_next", 3, 0, 8'h00, 0, 0, 0, 1, 0, 8'hD2, 1, 0);

      // Reset asserted mid-PAYLOAD
      step("rst_in", 0, 1, 8'hE1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      step("rst_in", 1, 1, 8'hE2, 0, 0, 1, 0, 0, 8'h00, 1, 0);
      step("rst_in", 2, 1, 8'hE3, 1, 0, 1, 0, 0, 8'h00, 1, 0);
      step("rst_hdr", 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h02, 1, 0);
      step("rst_pay", 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hE1, 1, 0);
      check("rst_pre", 0, 0, 1, 0, 8'hE2, 1, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", 0, 1, 0, 0, 8'h00, 0, 0);
      @(negedge clk_w);
      rst_n = 1'b1;
      @(posedge clk_w);
      #1;
      step("rst_post", 0, 1, 8'hF1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      step("rst_post", 1, 1, 8'hF2, 1, 0, 1, 0, 0, 8'h00, 1, 0);
      step("rst_post", 2, 0, 8'h00, 0, 0, 0, 1, 0, 8'h01, 1, 0);
      step("rst_post", 3, 0, 8'h00, 0, 0, 0, 1, 0, 8'hF1, 1, 0);
      step("rst_post", 4, 0, 8'h00, 0, 0, 0, 1, 0, 8'hF2, 1, 0);
      step("rst_post", 5, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
